// File: rtl/viterbi_pkg.sv
// Shared types and trellis helpers for the 4-state (K=3, rate-1/2) Viterbi decoder.
// State encoding is {u_t, u_t-1}; decision bit n selects the odd predecessor of state n.
package viterbi_pkg;

    localparam int unsigned NUM_STATES   = 4;
    localparam int unsigned PM_W_DEFAULT = 8;

    typedef logic [1:0]              state_t;
    typedef logic [NUM_STATES-1:0]   dec_t;
    typedef logic [PM_W_DEFAULT-1:0] pm_t;

    typedef enum logic [1:0] {
        StFill,
        StTrace,
        StOutput
    } fsm_state_e;

    function automatic state_t prev_state(state_t n, dec_t d);
        return {n[0], d[n]};
    endfunction

endpackage

// File: rtl/viterbi_traceback_unit_best_state_sel.sv
// Combinational 4-way unsigned argmin over path metrics.
// Ties resolve to the lowest state index.
module best_state_sel
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_W = 8
) (
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [PM_W-1:0] pm2_i,
    input  logic [PM_W-1:0] pm3_i,
    output state_t          best_o
);

    logic [PM_W-1:0] min01;
    logic [PM_W-1:0] min23;
    state_t          idx01;
    state_t          idx23;

    // Strict less-than everywhere so an equal metric never displaces a lower index.
    always_comb begin
        idx01  = (pm1_i < pm0_i) ? 2'd1 : 2'd0;
        min01  = (pm1_i < pm0_i) ? pm1_i : pm0_i;
        idx23  = (pm3_i < pm2_i) ? 2'd3 : 2'd2;
        min23  = (pm3_i < pm2_i) ? pm3_i : pm2_i;
        best_o = (min23 < min01) ? idx23 : idx01;
    end

endmodule

// File: rtl/viterbi_traceback_unit.sv
// Survivor memory and traceback for the 4-state Viterbi decoder: buffers one frame of
// decisions, traces back from the best final state, then streams bits in forward order.
module viterbi_traceback_unit
    import viterbi_pkg::*;
#(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned PM_W    = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            dec_valid_i,
    output logic            dec_ready_o,
    input  logic [3:0]      dec_bits_i,
    input  logic            dec_last_i,
    input  logic [PM_W-1:0] pm_s0_i,
    input  logic [PM_W-1:0] pm_s1_i,
    input  logic [PM_W-1:0] pm_s2_i,
    input  logic [PM_W-1:0] pm_s3_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            out_bit_o,
    output logic            out_last_o,
    output logic            busy_o
);

    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned LW = AW + 1;

    fsm_state_e         state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      len_q, len_d;
    state_t             st_q, st_d;
    logic [MAX_LEN-1:0] bitbuf_q, bitbuf_d;
    dec_t               mem_q [MAX_LEN];
    logic               dec_we;
    logic               last_bit;
    state_t             best_state;

    best_state_sel #(
        .PM_W (PM_W)
    ) u_best_state_sel (
        .pm0_i  (pm_s0_i),
        .pm1_i  (pm_s1_i),
        .pm2_i  (pm_s2_i),
        .pm3_i  (pm_s3_i),
        .best_o (best_state)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        idx_d       = idx_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = len_q;
        st_d        = st_q;
        bitbuf_d    = bitbuf_q;
        dec_we      = 1'b0;
        last_bit    = 1'b0;
        dec_ready_o = 1'b0;
        out_valid_o = 1'b0;
        out_bit_o   = 1'b0;
        out_last_o  = 1'b0;
        busy_o      = 1'b0;

        unique case (state_q)
            StFill: begin
                dec_ready_o = 1'b1;
                if (dec_valid_i) begin
                    dec_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    // A full memory forces termination; the beat that fills it is kept.
                    if (dec_last_i || (wr_ptr_q == AW'(MAX_LEN - 1))) begin
                        len_d   = LW'(wr_ptr_q) + LW'(1);
                        idx_d   = wr_ptr_q;
                        st_d    = best_state;
                        state_d = StTrace;
                    end
                end
            end

            StTrace: begin
                busy_o          = 1'b1;
                bitbuf_d[idx_q] = st_q[1];
                st_d            = prev_state(st_q, mem_q[idx_q]);
                idx_d           = idx_q - AW'(1);
                if (idx_q == '0) begin
                    rd_ptr_d = '0;
                    state_d  = StOutput;
                end
            end

            StOutput: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                out_bit_o   = bitbuf_q[rd_ptr_q];
                last_bit    = (LW'(rd_ptr_q) == (len_q - LW'(1)));
                out_last_o  = last_bit;
                if (out_ready_i) begin
                    if (last_bit) begin
                        rd_ptr_d = '0;
                        wr_ptr_d = '0;
                        state_d  = StFill;
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
            end

            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StFill;
            wr_ptr_q <= '0;
            idx_q    <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            st_q     <= '0;
            bitbuf_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            idx_q    <= idx_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            st_q     <= st_d;
            bitbuf_q <= bitbuf_d;
        end
    end

    // Decision memory is a plain register file with no reset.
    always_ff @(posedge clk_i) begin
        if (dec_we) begin
            mem_q[wr_ptr_q] <= dec_bits_i;
        end
    end

endmodule

// File: tb/tb_viterbi_traceback_unit.sv
// Randomised bench for viterbi_traceback_unit against a trellis-level traceback model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_viterbi_traceback_unit;

    localparam int unsigned MAX_LEN = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid;
    logic       dec_ready;
    logic [3:0] dec_bits;
    logic       dec_last;
    logic [7:0] pm0, pm1, pm2, pm3;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic       out_last;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    viterbi_traceback_unit #(
        .MAX_LEN (MAX_LEN),
        .PM_W    (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .dec_valid_i (dec_valid),
        .dec_ready_o (dec_ready),
        .dec_bits_i  (dec_bits),
        .dec_last_i  (dec_last),
        .pm_s0_i     (pm0),
        .pm_s1_i     (pm1),
        .pm_s2_i     (pm2),
        .pm_s3_i     (pm3),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_bit_o   (out_bit),
        .out_last_o  (out_last),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Argmin with lowest-index ties, then walk predecessors backwards; bit t is the
    // MSB of the state the path occupies after step t.
    function automatic logic [63:0] model_bits(input logic [3:0] decs[$],
                                               input int p0, input int p1,
                                               input int p2, input int p3);
        int pm[4];
        int best;
        int st;
        logic [63:0] r;
        pm[0] = p0; pm[1] = p1; pm[2] = p2; pm[3] = p3;
        best = 0;
        for (int s = 1; s < 4; s++) if (pm[s] < pm[best]) best = s;
        st = best;
        r  = '0;
        for (int t = decs.size() - 1; t >= 0; t--) begin
            r[t] = (st >= 2);
            st   = (st % 2) * 2 + int'(decs[t][st]);
        end
        return r;
    endfunction

    task automatic frame_in(input logic [3:0] decs[$], input bit use_last,
                            input logic [7:0] f0, input logic [7:0] f1,
                            input logic [7:0] f2, input logic [7:0] f3,
                            input bit keep_valid, output int acc_first,
                            output int acc_last, output bit timeout);
        int n;
        int budget;
        n = decs.size();
        timeout = 1'b0;
        acc_first = -1;
        acc_last = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dec_valid = 1'b1;
            dec_bits  = decs[i];
            dec_last  = use_last && (i == n - 1);
            if (i == n - 1) begin
                pm0 = f0; pm1 = f1; pm2 = f2; pm3 = f3;
            end else begin
                pm0 = 8'($urandom); pm1 = 8'($urandom);
                pm2 = 8'($urandom); pm3 = 8'($urandom);
            end
            budget = 0;
            while (!dec_ready && !timeout) begin
                @(negedge clk);
                budget++;
                if (budget > 3000) timeout = 1'b1;
            end
            if (timeout) break;
            if (i == 0) acc_first = cyc;
            acc_last = cyc;
        end
        if (!keep_valid || timeout) begin
            @(posedge clk);
            #1;
            dec_valid = 1'b0;
            dec_last  = 1'b0;
        end
    endtask

    task automatic collect(input int n, input bit rnd_ready, output logic [63:0] bits_v,
                           output logic [63:0] last_v, output int first_cyc,
                           output int last_cyc, output bit side_bad, output bit timeout);
        int got;
        int budget;
        bits_v = '0; last_v = '0; first_cyc = -1; last_cyc = -1;
        side_bad = 1'b0; timeout = 1'b0; got = 0; budget = 0;
        while (got < n && !timeout) begin
            @(negedge clk);
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (dec_ready || !busy) side_bad = 1'b1;
                if (out_ready) begin
                    bits_v[got] = out_bit;
                    last_v[got] = out_last;
                    last_cyc = cyc;
                    got++;
                end
            end
            budget++;
            if (budget > 3000) timeout = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; dec_valid = 1'b0; dec_bits = '0; dec_last = 1'b0;
        pm0 = '0; pm1 = '0; pm2 = '0; pm3 = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL reset_dec_ready got=%b exp=1", dec_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_bit !== 1'b0) begin failures++; $display("FAIL reset_out_bit got=%b exp=0", out_bit); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_known_path;
        logic [3:0] d[$];
        logic [63:0] bv, lv;
        int af, al, fc, lc;
        bit to, tc, sb;
        d = {4'b0000, 4'b0000, 4'b0100, 4'b0000};
        frame_in(d, 1'b1, 8'd9, 8'd7, 8'd5, 8'd0, 1'b0, af, al, to);
        collect(4, 1'b0, bv, lv, fc, lc, sb, tc);
        checks++; if (to || tc) begin failures++; $display("FAIL known_timeout in=%0b out=%0b", to, tc); end
        checks++; if (bv[3:0] !== 4'b1101) begin failures++; $display("FAIL known_bits got=%b exp=1101", bv[3:0]); end
        checks++; if (lv !== 64'h8) begin failures++; $display("FAIL known_last got=%h exp=8", lv); end
        checks++; if (fc - al !== 5) begin failures++; $display("FAIL known_latency got=%0d exp=5", fc - al); end
        checks++; if (sb) begin failures++; $display("FAIL known_side got=1 exp=0 (dec_ready/busy during output)"); end
    endtask

    task automatic test_tie_break;
        logic [3:0] d[$];
        logic [63:0] bv, lv, exp;
        int af, al, fc, lc;
        bit to, tc, sb;
        d = {4'b0000, 4'b0000, 4'b0000};
        frame_in(d, 1'b1, 8'd12, 8'd12, 8'd12, 8'd12, 1'b0, af, al, to);
        collect(3, 1'b1, bv, lv, fc, lc, sb, tc);
        exp = model_bits(d, 12, 12, 12, 12);
        checks++; if (to || tc || bv !== exp) begin failures++; $display("FAIL tie_all got=%h exp=%h to=%0b", bv, exp, to | tc); end
        frame_in(d, 1'b1, 8'd12, 8'd3, 8'd3, 8'd40, 1'b0, af, al, to);
        collect(3, 1'b1, bv, lv, fc, lc, sb, tc);
        exp = model_bits(d, 12, 3, 3, 40);
        checks++; if (to || tc || bv !== exp) begin failures++; $display("FAIL tie_pair got=%h exp=%h to=%0b", bv, exp, to | tc); end
        checks++; if (lv !== 64'h4) begin failures++; $display("FAIL tie_last got=%h exp=4", lv); end
    endtask

    task automatic test_backpressure;
        logic [3:0] d[$];
        logic [63:0] bv, lv, exp;
        logic b0;
        int af, al, fc, lc, w;
        bit to, tc, sb, stable_bad;
        d = {};
        for (int i = 0; i < 6; i++) d.push_back(4'($urandom));
        frame_in(d, 1'b1, 8'd20, 8'd30, 8'd2, 8'd50, 1'b0, af, al, to);
        exp = model_bits(d, 20, 30, 2, 50);
        out_ready = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!out_valid && w < 200);
        checks++; if (!out_valid) begin failures++; $display("FAIL bp_wait got=0 exp=1 (out_valid)"); end
        out_ready = 1'b1;
        b0 = out_bit;
        @(negedge clk);
        out_ready = 1'b0;
        stable_bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_bit !== exp[1] || out_last !== 1'b0 || dec_ready !== 1'b0)
                stable_bad = 1'b1;
        end
        checks++; if (stable_bad) begin failures++; $display("FAIL bp_hold got=bit%b,last%b exp=bit%b,last0", out_bit, out_last, exp[1]); end
        collect(5, 1'b1, bv, lv, fc, lc, sb, tc);
        bv = {bv[62:0], b0};
        checks++; if (tc || bv !== exp) begin failures++; $display("FAIL bp_bits got=%h exp=%h", bv, exp); end
    endtask

    task automatic test_forced_term;
        logic [3:0] d[$];
        logic [3:0] d1[$];
        logic [63:0] bv, lv, bv1, lv1, exp1;
        int af, al, af1, al1, fc, lc, fc1, lc1;
        bit to, to1, tc, tc1, sb, sb1;
        d = {};
        for (int i = 0; i < 64; i++) d.push_back(4'b1111);
        d1 = {4'($urandom)};
        frame_in(d, 1'b0, 8'd5, 8'd5, 8'd5, 8'd1, 1'b1, af, al, to);
        fork
            frame_in(d1, 1'b1, 8'd7, 8'd3, 8'd9, 8'd4, 1'b0, af1, al1, to1);
            collect(64, 1'b1, bv, lv, fc, lc, sb, tc);
        join
        checks++; if (to || tc || bv !== {64{1'b1}}) begin failures++; $display("FAIL forced_bits got=%h exp=ffffffffffffffff", bv); end
        checks++; if (lv !== 64'h8000000000000000) begin failures++; $display("FAIL forced_last got=%h exp=8000000000000000", lv); end
        checks++; if (to1 || af1 <= lc) begin failures++; $display("FAIL forced_beat65 accepted_at=%0d required_after=%0d", af1, lc); end
        collect(1, 1'b0, bv1, lv1, fc1, lc1, sb1, tc1);
        exp1 = model_bits(d1, 7, 3, 9, 4);
        checks++; if (tc1 || bv1 !== exp1 || lv1 !== 64'h1) begin failures++; $display("FAIL single_step got=%h/%h exp=%h/1", bv1, lv1, exp1); end
    endtask

    task automatic test_reset_mid_trace;
        logic [3:0] d[$];
        logic [63:0] bv, lv, exp;
        int af, al, fc, lc;
        bit to, tc, sb, leak;
        d = {};
        for (int i = 0; i < 10; i++) d.push_back(4'($urandom));
        frame_in(d, 1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0, af, al, to);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (dec_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_trace got=rdy%b,vld%b,busy%b exp=rdy1,vld0,busy0", dec_ready, out_valid, busy);
        end
        leak = 1'b0;
        out_ready = 1'b1;
        repeat (20) begin @(negedge clk); if (out_valid) leak = 1'b1; end
        checks++; if (leak) begin failures++; $display("FAIL rst_no_output got=1 exp=0"); end
        d = {4'($urandom), 4'($urandom)};
        frame_in(d, 1'b1, 8'd8, 8'd6, 8'd6, 8'd9, 1'b0, af, al, to);
        collect(2, 1'b1, bv, lv, fc, lc, sb, tc);
        exp = model_bits(d, 8, 6, 6, 9);
        checks++; if (to || tc || bv !== exp || lv !== 64'h2) begin failures++; $display("FAIL rst_new_frame got=%h/%h exp=%h/2", bv, lv, exp); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] d1[$];
        logic [3:0] d2[$];
        logic [63:0] b1, l1, b2, l2, e1, e2;
        int a1f, a1l, a2f, a2l, f1, c1, f2, c2;
        bit t1, t2, tc1, tc2, s1, s2;
        d1 = {}; d2 = {};
        for (int i = 0; i < 4; i++) begin d1.push_back(4'($urandom)); d2.push_back(4'($urandom)); end
        frame_in(d1, 1'b1, 8'd40, 8'd30, 8'd20, 8'd25, 1'b1, a1f, a1l, t1);
        fork
            frame_in(d2, 1'b1, 8'd3, 8'd3, 8'd1, 8'd1, 1'b0, a2f, a2l, t2);
            collect(4, 1'b1, b1, l1, f1, c1, s1, tc1);
        join
        collect(4, 1'b1, b2, l2, f2, c2, s2, tc2);
        e1 = model_bits(d1, 40, 30, 20, 25);
        e2 = model_bits(d2, 3, 3, 1, 1);
        checks++; if (t1 || tc1 || b1 !== e1) begin failures++; $display("FAIL b2b_first got=%h exp=%h", b1, e1); end
        checks++; if (t2 || tc2 || b2 !== e2) begin failures++; $display("FAIL b2b_second got=%h exp=%h", b2, e2); end
        checks++; if (a2f <= c1) begin failures++; $display("FAIL b2b_order accepted_at=%0d required_after=%0d", a2f, c1); end
    endtask

    task automatic test_random_frames;
        logic [3:0] d[$];
        logic [63:0] bv, lv, exp, exp_last;
        logic [7:0] p[4];
        int n, af, al, fc, lc;
        bit to, tc, sb;
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, MAX_LEN);
            d = {};
            for (int i = 0; i < n; i++) d.push_back(4'($urandom));
            for (int s = 0; s < 4; s++) p[s] = 8'($urandom_range(0, 15));
            frame_in(d, 1'b1, p[0], p[1], p[2], p[3], 1'b0, af, al, to);
            collect(n, 1'b1, bv, lv, fc, lc, sb, tc);
            exp = model_bits(d, p[0], p[1], p[2], p[3]);
            exp_last = '0;
            exp_last[n - 1] = 1'b1;
            checks++; if (to || tc || bv !== exp || lv !== exp_last) begin
                failures++; $display("FAIL rand_frame%0d len=%0d got=%h/%h exp=%h/%h", f, n, bv, lv, exp, exp_last);
            end
            checks++; if (fc - al !== n + 1 || sb) begin
                failures++; $display("FAIL rand_latency%0d got=%0d exp=%0d side=%0b", f, fc - al, n + 1, sb);
            end
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || dec_ready !== 1'b1) begin
                failures++; $display("FAIL rand_return%0d got=vld%b,rdy%b exp=vld0,rdy1", f, out_valid, dec_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_path();
        test_tie_break();
        test_backpressure();
        test_forced_term();
        test_reset_mid_trace();
        test_back_to_back();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
